// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types for the instruction fetch slice.
// WORD_SIZE is the machine word width used for both pc (word address) and instruction words.
// fetch_state_t is the fetch FSM encoding; fetch_entry_t is one buffered {pc, inst} pair.
package fetch_pkg;

    localparam int WORD_SIZE = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // free to issue a request
        WAIT = 2'd1,  // one request outstanding, response will be kept
        DROP = 2'd2   // one request outstanding, response will be discarded
    } fetch_state_t;

    typedef struct packed {
        logic [WORD_SIZE-1:0] pc;
        logic [WORD_SIZE-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry buffer of fetch_entry_t between fetch and decode.
// Latency: a push is visible at the head one cycle later; head is read combinationally.
// Backpressure: caller must not push when full nor pop when empty; flush wins over push/pop.
// Ports: clk, rst (async, active-high), push_i/push_dat_i, pop_i, flush_i, head_o, count_o.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  fetch_entry_t               push_dat_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output fetch_entry_t               head_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [CW-1:0]  count_q;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: count_q gates every read of it.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: consumes pc, reads imem over req/ack, buffers {pc, inst} for decode.
// Latency: req in the cycle pc is presented, head valid the cycle after ack; peak 1 inst / 2 cycles.
// Backpressure: fetch_halt holds pc while a request cannot issue; pc_bj flushes and cancels in-flight reads.
// Ports: clk, rst (async, active-high); pc_in/pc_bj/fetch_halt to pc; imem_req/addr/ack/rdata to memory;
//        inst_valid/ready/data/pc to decode; stat_fetched/stat_stall counters.
// Optional feature macro FETCH_STATS_EN: when undefined the stat ports are tied to zero.
module inst_fetch
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] pc_in,
    input  logic                 pc_bj,
    output logic                 fetch_halt,
    output logic                 imem_req,
    output logic [WORD_SIZE-1:0] imem_addr,
    input  logic                 imem_ack,
    input  logic [WORD_SIZE-1:0] imem_rdata,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic [WORD_SIZE-1:0] inst_data,
    output logic [WORD_SIZE-1:0] inst_pc,
    output logic [31:0]          stat_fetched,
    output logic [31:0]          stat_stall
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t         state_q;
    logic [WORD_SIZE-1:0] addr_q;
    logic [CW-1:0]        count;
    fetch_entry_t         head;
    fetch_entry_t         push_dat;
    logic                 push;
    logic                 pop;

    // A redirect suppresses issue and forces halt low: pc gives halt priority
    // over pc_bj, so holding halt here would swallow the redirect.
    assign imem_req   = (state_q == IDLE) && (count < CW'(DEPTH)) && !pc_bj;
    assign fetch_halt = !imem_req && !pc_bj;

    assign push       = (state_q == WAIT) && imem_ack && !pc_bj;
    assign inst_valid = (count != '0) && !pc_bj;
    assign pop        = inst_valid && inst_ready;
    assign push_dat   = '{pc: addr_q, inst: imem_rdata};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // A stray ack in IDLE (e.g. after reset) is ignored.
                    if (imem_req) begin
                        addr_q  <= pc_in;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_ack)   state_q <= IDLE;  // pushed, or discarded if pc_bj
                    else if (pc_bj) state_q <= DROP;
                end
                DROP: begin
                    if (imem_ack) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .flush_i    (pc_bj),
        .head_o     (head),
        .count_o    (count)
    );

    assign imem_addr = addr_q;
    assign inst_data = head.inst;
    assign inst_pc   = head.pc;

`ifdef FETCH_STATS_EN
    logic [31:0] fetched_q;
    logic [31:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetched_q <= '0;
            stall_q   <= '0;
        end else begin
            if (push)       fetched_q <= fetched_q + 32'd1;
            if (fetch_halt) stall_q   <= stall_q + 32'd1;
        end
    end

    assign stat_fetched = fetched_q;
    assign stat_stall   = stall_q;
`else
    assign stat_fetched = 32'h0;
    assign stat_stall   = 32'h0;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;
    import fetch_pkg::*;

    localparam int DEPTH = 4;
    localparam int W     = WORD_SIZE;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] pc_in;
    logic         pc_bj;
    logic         fetch_halt;
    logic         imem_req;
    logic [W-1:0] imem_addr;
    logic         imem_ack;
    logic [W-1:0] imem_rdata;
    logic         inst_valid;
    logic         inst_ready;
    logic [W-1:0] inst_data;
    logic [W-1:0] inst_pc;
    logic [31:0]  stat_fetched;
    logic [31:0]  stat_stall;

    always #5 clk = ~clk;

    inst_fetch #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_in        (pc_in),
        .pc_bj        (pc_bj),
        .fetch_halt   (fetch_halt),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .inst_data    (inst_data),
        .inst_pc      (inst_pc),
        .stat_fetched (stat_fetched),
        .stat_stall   (stat_stall)
    );

    // Reference model: expected decode queue, one outstanding read, the pc register.
    fetch_entry_t exp_q[$];
    bit           out_vld;
    bit           out_cancel;
    logic [W-1:0] out_pc;
    logic [W-1:0] pc;
    logic [31:0]  exp_fetched;
    logic [31:0]  exp_stall;

    // Memory responder state.
    int           rem;
    int           stale_rem;
    logic [W-1:0] raddr;

    // Stimulus knobs.
    int           lat_min = 1;
    int           lat_max = 1;
    int           p_bj    = 0;
    int           p_ready = 100;
    int           p_stray = 0;
    bit           force_bj = 1'b0;
    logic [W-1:0] force_tgt;
    logic [W-1:0] bj_tgt;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [W-1:0] mem(input logic [W-1:0] a);
        return 32'hC0DE0000 ^ a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    // Drive inputs for the cycle that just started (called 1 time unit after posedge).
    task automatic drive();
        pc_in = pc;
        if (force_bj) begin
            pc_bj    = 1'b1;
            bj_tgt   = force_tgt;
            force_bj = 1'b0;
        end else begin
            pc_bj  = (int'($urandom_range(0, 99)) < p_bj);
            bj_tgt = W'($urandom_range(0, 1023));
        end
        inst_ready = (int'($urandom_range(0, 99)) < p_ready);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        if (rem > 0) begin
            rem--;
            if (rem == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem(raddr);
            end
        end
        // Late response to a request issued before a reset.
        if (stale_rem > 0) begin
            stale_rem--;
            if (stale_rem == 0 && !imem_ack && !out_vld) begin
                imem_ack   = 1'b1;
                imem_rdata = 32'hDEADBEEF;
            end
        end
        if (!imem_ack && !out_vld && rem == 0 && int'($urandom_range(0, 99)) < p_stray)
            imem_ack = 1'b1;
    endtask

    // Compare outputs at negedge, then advance the model across the next posedge.
    task automatic step();
        bit exp_req, exp_halt, exp_valid, push, pop;
        @(negedge clk);
        exp_req   = !out_vld && (exp_q.size() < DEPTH) && !pc_bj;
        exp_halt  = !exp_req && !pc_bj;
        exp_valid = (exp_q.size() != 0) && !pc_bj;
        check_b("imem_req", imem_req, exp_req);
        check_b("fetch_halt", fetch_halt, exp_halt);
        check_b("inst_valid", inst_valid, exp_valid);
        if (exp_valid) begin
            check("inst_pc", inst_pc, exp_q[0].pc);
            check("inst_data", inst_data, exp_q[0].inst);
        end
        if (out_vld) check("imem_addr", imem_addr, out_pc);
`ifdef FETCH_STATS_EN
        check("stat_fetched", stat_fetched, exp_fetched);
        check("stat_stall", stat_stall, exp_stall);
`else
        check("stat_fetched", stat_fetched, 32'h0);
        check("stat_stall", stat_stall, 32'h0);
`endif
        push = out_vld && imem_ack && !out_cancel && !pc_bj;
        pop  = exp_valid && inst_ready;
        @(posedge clk);
        if (exp_halt) exp_stall++;
        if (pc_bj) exp_q.delete();
        else if (pop) void'(exp_q.pop_front());
        if (push) begin
            exp_q.push_back('{pc: out_pc, inst: mem(out_pc)});
            exp_fetched++;
        end
        if (out_vld && imem_ack) out_vld = 1'b0;
        else if (out_vld && pc_bj) out_cancel = 1'b1;
        if (exp_req) begin
            out_vld    = 1'b1;
            out_cancel = 1'b0;
            out_pc     = pc;
            raddr      = pc;
            rem        = int'($urandom_range(lat_max, lat_min));
        end
        if (pc_bj) pc = bj_tgt;
        else if (!exp_halt) pc = pc + 1;
        #1;
        drive();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Assert reset mid-cycle, check immediate output values, release after two edges.
    task automatic do_reset();
        rst   = 1'b1;
        pc_bj = 1'b0;
        #1;
        check("rst imem_addr", imem_addr, 32'h0);
        check_b("rst inst_valid", inst_valid, 1'b0);
        check_b("rst imem_req", imem_req, 1'b1);
        check_b("rst fetch_halt", fetch_halt, 1'b0);
`ifdef FETCH_STATS_EN
        check("rst stat_fetched", stat_fetched, 32'h0);
        check("rst stat_stall", stat_stall, 32'h0);
`endif
        exp_q.delete();
        out_vld     = 1'b0;
        out_cancel  = 1'b0;
        pc          = '0;
        exp_fetched = '0;
        exp_stall   = '0;
        stale_rem   = rem;
        rem         = 0;
        @(posedge clk);
        #1;
        drive();
        pc_bj = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive();
    endtask

    task automatic knobs(input int lmin, input int lmax, input int bj, input int rdy, input int stray);
        lat_min = lmin; lat_max = lmax; p_bj = bj; p_ready = rdy; p_stray = stray;
    endtask

    initial begin
        rst = 1'b1; pc_in = '0; pc_bj = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        inst_ready = 1'b0; rem = 0; stale_rem = 0; raddr = '0; out_pc = '0;
        pc = '0; exp_fetched = '0; exp_stall = '0; force_tgt = '0; bj_tgt = '0;

        // 1: latency 1, always ready: heads {0,I0},{1,I1},{2,I2} every other cycle.
        knobs(1, 1, 0, 100, 0);
        do_reset();
        steps(2); settle();
        check_b("t1 valid c2", inst_valid, 1'b1);
        check("t1 pc c2", inst_pc, 32'd0);
        check("t1 data c2", inst_data, 32'hC0DE0000);
        steps(1); settle();
        check_b("t1 valid c3", inst_valid, 1'b0);
        steps(1); settle();
        check("t1 pc c4", inst_pc, 32'd1);
        check("t1 data c4", inst_data, 32'hC0DE0001);
        steps(2); settle();
        check("t1 pc c6", inst_pc, 32'd2);
        check("t1 data c6", inst_data, 32'hC0DE0002);

        // 2: decode stalled, FIFO fills after 4 pushes, then pc 4 is fetched.
        knobs(1, 1, 0, 0, 0);
        do_reset();
        steps(9); settle();
        check_b("t2 req full", imem_req, 1'b0);
        check_b("t2 halt full", fetch_halt, 1'b1);
        check("t2 head", inst_pc, 32'd0);
`ifdef FETCH_STATS_EN
        check("t2 fetched", stat_fetched, 32'd4);
        check("t2 stall", stat_stall, 32'd5);
`endif
        p_ready = 100;
        steps(3); settle();
        check("t2 refill addr", imem_addr, 32'd4);

        // 3: redirect while waiting, ack 3 cycles after req is dropped.
        knobs(3, 3, 0, 100, 0);
        do_reset();
        force_bj = 1'b1; force_tgt = 32'h40;
        steps(1); settle();
        check_b("t3 halt on bj", fetch_halt, 1'b0);
        check_b("t3 req on bj", imem_req, 1'b0);
        steps(2); settle();
        check_b("t3 req drop", imem_req, 1'b0);
        steps(1); settle();
        check_b("t3 req after", imem_req, 1'b1);
        check_b("t3 empty", inst_valid, 1'b0);
        steps(1); settle();
        check("t3 new addr", imem_addr, 32'h40);

        // 4: redirect coincides with ack and a pop.
        knobs(1, 1, 0, 0, 0);
        do_reset();
        steps(2);
        force_bj = 1'b1; force_tgt = 32'h80; p_ready = 100;
        steps(1); settle();
        check_b("t4 valid bj", inst_valid, 1'b0);
        steps(1); settle();
        check_b("t4 valid after", inst_valid, 1'b0);
        check_b("t4 req after", imem_req, 1'b1);
        steps(1); settle();
        check("t4 new addr", imem_addr, 32'h80);

        // 5: reset in WAIT, late ack lands in IDLE afterwards and must be ignored.
        knobs(1, 1, 0, 100, 0);
        do_reset();
        steps(2);
        lat_min = 5; lat_max = 5;
        steps(1); settle();
        check("t5 addr pre", imem_addr, 32'd1);
        lat_min = 1; lat_max = 1;
        do_reset();
        steps(2); settle();
        check("t5 pc c2", inst_pc, 32'd0);
        check("t5 data c2", inst_data, 32'hC0DE0000);
        steps(2); settle();
        check_b("t5 valid c4", inst_valid, 1'b1);
        check("t5 pc c4", inst_pc, 32'd1);

        // Randomized traffic against the model.
        knobs(1, 4, 8, 60, 5);
        do_reset();
        steps(4000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
